// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: fetches from a BUS_W-wide bus into a small word queue
// and redirects on an illegal-instruction trap or a jump.
module prefetch_unit #(
  parameter int          BUS_W        = 16,
  parameter int          DEPTH        = 2,
  parameter logic [63:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00
) (
  input  logic             clk_i,
  input  logic             reset_i,
  output logic [63:0]      adr_o,
  output logic [1:0]       size_o,
  input  logic [BUS_W-1:0] dat_i,
  input  logic             ack_i,
  output logic [31:0]      ir_o,
  output logic [63:0]      pc_o,
  output logic             ir_valid_o,
  input  logic             ir_ready_i,
  input  logic             defined_i,
  input  logic             jump_i,
  input  logic [63:0]      jump_adr_i,
  input  logic [63:2]      csr_mtvec_i,
  output logic             mpie_mie_o,
  output logic             mie_0_o,
  output logic             mcause_2_o
);

  localparam int          PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW          = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [PW-1:0] LAST      = PW'(DEPTH - 1);
  localparam logic [63:0] STEP        = 64'(BUS_W / 8);
  localparam logic [1:0]  SIZE_ACTIVE = (BUS_W == 32) ? 2'd3 : 2'd2;

  logic [31:0]   ir_q [DEPTH];
  logic [63:0]   pc_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [63:0]   adr_q;
  logic          trap, redirect, pop, fetch_en, beat;
  logic          push;
  logic [31:0]   push_word;
  logic [63:0]   push_pc;
  logic          unused_adr_bits;

  assign unused_adr_bits = ^jump_adr_i[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    ir_valid_o = (count != '0);
    trap       = ir_valid_o & ~defined_i;
    redirect   = trap | jump_i;
    pop        = ir_valid_o & ir_ready_i & ~redirect;
    // A pop in this cycle frees a slot for the beat completing on the same edge.
    fetch_en   = ((count != FULL) | pop) & ~redirect & ~reset_i;
    size_o     = fetch_en ? SIZE_ACTIVE : 2'd0;
    beat       = fetch_en & ack_i;
  end

  assign adr_o      = adr_q;
  assign ir_o       = ir_q[rd_ptr];
  assign pc_o       = pc_q[rd_ptr];
  assign mpie_mie_o = trap;
  assign mie_0_o    = trap;
  assign mcause_2_o = trap;

  generate
    if (BUS_W == 32) begin : g_w32
      assign push      = beat;
      assign push_word = dat_i;
      assign push_pc   = adr_q;
    end else begin : g_w16
      logic [15:0] half_lo;
      logic [63:0] half_pc;
      logic        half_valid;

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          half_valid <= 1'b0;
          half_lo    <= '0;
          half_pc    <= '0;
        end else if (redirect) begin
          half_valid <= 1'b0;
        end else if (beat) begin
          if (half_valid) begin
            half_valid <= 1'b0;
          end else begin
            half_valid <= 1'b1;
            half_lo    <= dat_i;
            half_pc    <= adr_q;
          end
        end
      end

      assign push      = beat & half_valid;
      assign push_word = {dat_i, half_lo};
      assign push_pc   = half_pc;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      adr_q <= RESET_VECTOR;
    end else if (trap) begin
      adr_q <= {csr_mtvec_i, 2'b00};
    end else if (jump_i) begin
      adr_q <= {jump_adr_i[63:2], 2'b00};
    end else if (beat) begin
      adr_q <= adr_q + STEP;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      ir_q[wr_ptr] <= push_word;
      pc_q[wr_ptr] <= push_pc;
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: a 16-bit instance driven from a vector table
// plus hand sequences for trap, reset abort and a 32-bit instance for jump/full cases.
module tb_prefetch_unit;

  localparam logic [63:0] RV = 64'hFFFF_FFFF_FFFF_FF00;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ack_i, ir_ready_i, defined_i, jump_i;
  logic [15:0] dat16;
  logic [31:0] dat32;
  logic [63:0] jump_adr_i;
  logic [63:2] csr_mtvec_i;

  logic [63:0] adr16, pc16, adr32, pc32;
  logic [1:0]  size16, size32;
  logic [31:0] ir16, ir32;
  logic        valid16, valid32;
  logic        mpie16, mie16, mcause16, mpie32, mie32, mcause32;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  prefetch_unit u16 (
    .clk_i(clk_i), .reset_i(reset_i), .adr_o(adr16), .size_o(size16),
    .dat_i(dat16), .ack_i(ack_i), .ir_o(ir16), .pc_o(pc16),
    .ir_valid_o(valid16), .ir_ready_i(ir_ready_i), .defined_i(defined_i),
    .jump_i(jump_i), .jump_adr_i(jump_adr_i), .csr_mtvec_i(csr_mtvec_i),
    .mpie_mie_o(mpie16), .mie_0_o(mie16), .mcause_2_o(mcause16)
  );

  prefetch_unit #(.BUS_W(32), .DEPTH(2)) u32 (
    .clk_i(clk_i), .reset_i(reset_i), .adr_o(adr32), .size_o(size32),
    .dat_i(dat32), .ack_i(ack_i), .ir_o(ir32), .pc_o(pc32),
    .ir_valid_o(valid32), .ir_ready_i(ir_ready_i), .defined_i(defined_i),
    .jump_i(jump_i), .jump_adr_i(jump_adr_i), .csr_mtvec_i(csr_mtvec_i),
    .mpie_mie_o(mpie32), .mie_0_o(mie32), .mcause_2_o(mcause32)
  );

  typedef struct {
    logic        ack;
    logic [15:0] dat;
    logic        rdy;
    logic [1:0]  size;
    logic [63:0] adr;
    logic        valid;
    logic [31:0] ir;
    logic [63:0] pc;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic [15:0] d16, input logic [31:0] d32,
                       input logic rdy, input logic def, input logic jmp);
    @(negedge clk_i);
    ack_i = a; dat16 = d16; dat32 = d32;
    ir_ready_i = rdy; defined_i = def; jump_i = jmp;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1; ack_i = 1'b0; ir_ready_i = 1'b0; defined_i = 1'b1; jump_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 16'hAAAA, 1'b0, 2'd2, RV,        1'b0, 32'h0,         64'h0};
    tbl[1]  = '{1'b1, 16'hBBBB, 1'b0, 2'd2, RV + 2,    1'b0, 32'h0,         64'h0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 2'd2, RV + 4,    1'b1, 32'hBBBB_AAAA, RV};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 2'd2, RV + 4,    1'b1, 32'hBBBB_AAAA, RV};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 2'd2, RV + 4,    1'b1, 32'hBBBB_AAAA, RV};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 2'd2, RV + 4,    1'b1, 32'hBBBB_AAAA, RV};
    tbl[6]  = '{1'b1, 16'h1111, 1'b0, 2'd2, RV + 4,    1'b1, 32'hBBBB_AAAA, RV};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 2'd2, RV + 6,    1'b1, 32'hBBBB_AAAA, RV};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 2'd2, RV + 6,    1'b1, 32'hBBBB_AAAA, RV};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 2'd2, RV + 6,    1'b1, 32'hBBBB_AAAA, RV};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 2'd2, RV + 6,    1'b1, 32'hBBBB_AAAA, RV};
    tbl[11] = '{1'b1, 16'h2222, 1'b0, 2'd2, RV + 6,    1'b1, 32'hBBBB_AAAA, RV};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 2'd0, RV + 8,    1'b1, 32'hBBBB_AAAA, RV};
    tbl[13] = '{1'b1, 16'hEEEE, 1'b0, 2'd0, RV + 8,    1'b1, 32'hBBBB_AAAA, RV};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 2'd2, RV + 8,    1'b1, 32'hBBBB_AAAA, RV};
    tbl[15] = '{1'b1, 16'h3333, 1'b0, 2'd2, RV + 8,    1'b1, 32'h2222_1111, RV + 4};
    tbl[16] = '{1'b1, 16'h4444, 1'b0, 2'd2, RV + 'hA,  1'b1, 32'h2222_1111, RV + 4};
    tbl[17] = '{1'b0, 16'h0000, 1'b0, 2'd0, RV + 'hC,  1'b1, 32'h2222_1111, RV + 4};
    tbl[18] = '{1'b0, 16'h0000, 1'b1, 2'd2, RV + 'hC,  1'b1, 32'h2222_1111, RV + 4};
    tbl[19] = '{1'b0, 16'h0000, 1'b0, 2'd2, RV + 'hC,  1'b1, 32'h4444_3333, RV + 8};

    reset_i = 1'b1; ack_i = 1'b0; dat16 = '0; dat32 = '0; ir_ready_i = 1'b0;
    defined_i = 1'b1; jump_i = 1'b0; jump_adr_i = '0; csr_mtvec_i = '0;
    #1;
    chk("rst size16", 64'(size16), 64'd0);
    chk("rst size32", 64'(size32), 64'd0);
    chk("rst adr16", adr16, RV);
    chk("rst adr32", adr32, RV);
    chk("rst valid16", 64'(valid16), 64'd0);
    chk("rst strobe16", 64'(mpie16 | mie16 | mcause16), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].ack, tbl[i].dat, 32'h0, tbl[i].rdy, 1'b1, 1'b0);
      chk($sformatf("row%0d size", i), 64'(size16), 64'(tbl[i].size));
      chk($sformatf("row%0d adr", i), adr16, tbl[i].adr);
      chk($sformatf("row%0d valid", i), 64'(valid16), 64'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("row%0d ir", i), 64'(ir16), 64'(tbl[i].ir));
        chk($sformatf("row%0d pc", i), pc16, tbl[i].pc);
      end
    end

    // Trap with a half-word latched: the half and the acked beat must vanish.
    drive(1'b1, 16'h9999, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("pretrap adr", adr16, RV + 'hC);
    csr_mtvec_i = 62'h1DDD_DDDD_DDDD_DDDD;
    drive(1'b1, 16'h8888, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("trap mpie", 64'(mpie16), 64'd1);
    chk("trap mie", 64'(mie16), 64'd1);
    chk("trap mcause", 64'(mcause16), 64'd1);
    chk("trap size", 64'(size16), 64'd0);
    drive(1'b1, 16'hCCCC, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("post trap strobe", 64'(mpie16 | mie16 | mcause16), 64'd0);
    chk("post trap valid", 64'(valid16), 64'd0);
    chk("post trap size", 64'(size16), 64'd2);
    chk("post trap adr", adr16, 64'h7777_7777_7777_7774);
    drive(1'b1, 16'hDDDD, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("vec beat2 adr", adr16, 64'h7777_7777_7777_7776);
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("vec valid", 64'(valid16), 64'd1);
    chk("vec ir", 64'(ir16), 64'hDDDD_CCCC);
    chk("vec pc", pc16, 64'h7777_7777_7777_7774);

    // Reset mid-word discards the latched half.
    drive(1'b1, 16'h7777, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b1; ack_i = 1'b0; defined_i = 1'b0;
    #1;
    chk("midrst size", 64'(size16), 64'd0);
    chk("midrst adr", adr16, RV);
    chk("midrst valid", 64'(valid16), 64'd0);
    chk("midrst strobe", 64'(mpie16), 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0; defined_i = 1'b1;
    drive(1'b1, 16'h1234, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("rel size", 64'(size16), 64'd2);
    chk("rel adr", adr16, RV);
    drive(1'b1, 16'h5678, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("rel ir", 64'(ir16), 64'h5678_1234);
    chk("rel pc", pc16, RV);

    // 32-bit instance: latency, full push/pop ordering, jump and trap priority.
    do_reset();
    drive(1'b1, 16'h0, 32'h1111_1111, 1'b0, 1'b1, 1'b0);
    chk("w32 size", 64'(size32), 64'd3);
    chk("w32 adr0", adr32, RV);
    chk("w32 valid0", 64'(valid32), 64'd0);
    drive(1'b1, 16'h0, 32'h2222_2222, 1'b0, 1'b1, 1'b0);
    chk("w32 valid1", 64'(valid32), 64'd1);
    chk("w32 ir1", 64'(ir32), 64'h1111_1111);
    chk("w32 adr1", adr32, RV + 4);
    drive(1'b1, 16'h0, 32'h3333_3333, 1'b0, 1'b1, 1'b0);
    chk("w32 full size", 64'(size32), 64'd0);
    chk("w32 full adr", adr32, RV + 8);
    drive(1'b1, 16'h0, 32'h3333_3333, 1'b1, 1'b1, 1'b0);
    chk("w32 pushpop size", 64'(size32), 64'd3);
    chk("w32 pushpop ir", 64'(ir32), 64'h1111_1111);
    drive(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("w32 still full", 64'(size32), 64'd0);
    chk("w32 ir2", 64'(ir32), 64'h2222_2222);
    chk("w32 pc2", pc32, RV + 4);
    drive(1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("w32 ir3", 64'(ir32), 64'h3333_3333);
    chk("w32 pc3", pc32, RV + 8);
    chk("w32 adr3", adr32, RV + 'hC);
    jump_adr_i = 64'h1003;
    drive(1'b1, 16'h0, 32'h4444_4444, 1'b1, 1'b1, 1'b1);
    chk("jump size", 64'(size32), 64'd0);
    drive(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("jump flushed", 64'(valid32), 64'd0);
    chk("jump adr", adr32, 64'h1000);
    chk("jump size after", 64'(size32), 64'd3);
    drive(1'b1, 16'h0, 32'h5555_5555, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("jump ir", 64'(ir32), 64'h5555_5555);
    chk("jump pc", pc32, 64'h1000);
    jump_adr_i = 64'h2000;
    csr_mtvec_i = 62'h0C00;
    drive(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("both strobe", 64'(mcause32), 64'd1);
    chk("both size", 64'(size32), 64'd0);
    drive(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("both adr", adr32, 64'h3000);
    chk("both valid", 64'(valid32), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
